// File: rtl/remote_pkg.sv
// Shared NEC infrared definitions: transmitter FSM encoding, protocol unit
// counts, frame packing and the matching receiver-side frame decoder.
package remote_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } tx_state_t;

  localparam int LEAD_MARK_UNITS    = 16;
  localparam int LEAD_SPACE_UNITS   = 8;
  localparam int REPEAT_SPACE_UNITS = 4;
  localparam int BIT_MARK_UNITS     = 1;
  localparam int ZERO_SPACE_UNITS   = 1;
  localparam int ONE_SPACE_UNITS    = 3;
  localparam int STOP_MARK_UNITS    = 1;
  localparam int FRAME_BITS         = 32;

  typedef struct packed {
    logic       valid;
    logic [7:0] address;
    logic [7:0] command;
  } nec_decoded_t;

  function automatic logic is_mark(input tx_state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

  // Bit 0 goes on air first: Address, ~Address, Command, ~Command, each LSB first.
  function automatic logic [FRAME_BITS-1:0] nec_payload(input logic [7:0] address,
                                                        input logic [7:0] command);
    return {~command, command, ~address, address};
  endfunction

  function automatic nec_decoded_t nec_decode(input logic [FRAME_BITS-1:0] frame);
    nec_decoded_t d;
    d.address = frame[7:0];
    d.command = frame[23:16];
    d.valid   = (frame[15:8] == ~frame[7:0]) && (frame[31:24] == ~frame[23:16]);
    return d;
  endfunction

endpackage

// File: rtl/remote_carrier.sv
// Carrier modulator: gates a square wave onto the mark envelope, restarting
// the phase on every rising envelope so each mark begins with a high half-period.
module remote_carrier #(
  parameter int CARRIER_HALF = 658
) (
  input  logic Clk,
  input  logic Reset,
  input  logic envelope,
  input  logic envelope_next,
  output logic ir_out
);

  localparam int CNT_W = $clog2(CARRIER_HALF + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             ir_reg;

  // envelope_next is the value Envelope takes at this edge, so IR_Out lines up with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg <= '0;
      ir_reg  <= 1'b0;
    end else if (!envelope_next) begin
      cnt_reg <= '0;
      ir_reg  <= 1'b0;
    end else if (!envelope) begin
      cnt_reg <= '0;
      ir_reg  <= 1'b1;
    end else if (cnt_reg == CNT_W'(CARRIER_HALF - 1)) begin
      cnt_reg <= '0;
      ir_reg  <= ~ir_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign ir_out = ir_reg;

endmodule

// File: rtl/remote_transmitter.sv
// NEC infrared transmitter: sends data or repeat frames on a fixed frame
// period, producing a registered mark envelope and carrier-modulated LED drive.
module remote_transmitter
  import remote_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int FRAME_UNITS  = 192
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Valid,
  output logic       Ready,
  input  logic [7:0] Address,
  input  logic [7:0] Command,
  input  logic       Repeat,
  output logic       Envelope,
  output logic       IR_Out
);

  localparam int TICK_W  = $clog2(UNIT_CYCLES + 1);
  localparam int FRAME_W = $clog2(FRAME_UNITS + 1);
  localparam int SEG_W   = 5;
  localparam int BIT_W   = $clog2(FRAME_BITS);

  tx_state_t             state_reg;
  tx_state_t             state_next;
  logic [TICK_W-1:0]     tick_reg;
  logic [SEG_W-1:0]      seg_reg;
  logic [SEG_W-1:0]      seg_len;
  logic [FRAME_W-1:0]    frame_reg;
  logic [BIT_W-1:0]      bit_reg;
  logic [FRAME_BITS-1:0] shift_reg;
  logic                  repeat_reg;
  logic                  ready_reg;
  logic                  envelope_reg;
  logic                  mark_next;
  logic                  accept;
  logic                  unit_done;
  logic                  seg_done;
  logic                  frame_done;

  always_comb begin
    accept     = Valid && ready_reg && !Reset;
    unit_done  = (tick_reg == TICK_W'(UNIT_CYCLES - 1));
    frame_done = unit_done && (frame_reg == FRAME_W'(FRAME_UNITS - 1));

    // Length in units of the segment currently on air.
    seg_len = SEG_W'(1);
    case (state_reg)
      LEAD_MARK:  seg_len = SEG_W'(LEAD_MARK_UNITS);
      LEAD_SPACE: seg_len = repeat_reg ? SEG_W'(REPEAT_SPACE_UNITS) : SEG_W'(LEAD_SPACE_UNITS);
      BIT_MARK:   seg_len = SEG_W'(BIT_MARK_UNITS);
      BIT_SPACE:  seg_len = shift_reg[0] ? SEG_W'(ONE_SPACE_UNITS) : SEG_W'(ZERO_SPACE_UNITS);
      STOP_MARK:  seg_len = SEG_W'(STOP_MARK_UNITS);
      default:    seg_len = SEG_W'(1);
    endcase
    seg_done = unit_done && (seg_reg == seg_len - SEG_W'(1));

    state_next = state_reg;
    case (state_reg)
      IDLE:       if (accept)     state_next = LEAD_MARK;
      LEAD_MARK:  if (seg_done)   state_next = LEAD_SPACE;
      LEAD_SPACE: if (seg_done)   state_next = repeat_reg ? STOP_MARK : BIT_MARK;
      BIT_MARK:   if (seg_done)   state_next = BIT_SPACE;
      BIT_SPACE:  if (seg_done)   state_next = (bit_reg == BIT_W'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (seg_done)   state_next = GAP;
      GAP:        if (frame_done) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
    if (Reset) state_next = IDLE;

    mark_next = is_mark(state_next);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      tick_reg     <= '0;
      seg_reg      <= '0;
      frame_reg    <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      repeat_reg   <= 1'b0;
      ready_reg    <= 1'b1;
      envelope_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_reg    <= (state_next == IDLE);
      envelope_reg <= mark_next;
      if (accept) begin
        tick_reg   <= '0;
        seg_reg    <= '0;
        frame_reg  <= '0;
        bit_reg    <= '0;
        shift_reg  <= nec_payload(Address, Command);
        repeat_reg <= Repeat;
      end else if (state_reg != IDLE) begin
        // Every segment is a whole number of units, so one free-running tick serves all.
        tick_reg <= unit_done ? '0 : tick_reg + 1'b1;
        if (unit_done) begin
          frame_reg <= frame_reg + 1'b1;
          seg_reg   <= seg_done ? '0 : seg_reg + 1'b1;
        end
        if (seg_done && state_reg == BIT_SPACE) begin
          shift_reg <= shift_reg >> 1;
          bit_reg   <= bit_reg + 1'b1;
        end
      end
    end
  end

  remote_carrier #(
    .CARRIER_HALF (CARRIER_HALF)
  ) u_carrier (
    .Clk           (Clk),
    .Reset         (Reset),
    .envelope      (envelope_reg),
    .envelope_next (mark_next),
    .ir_out        (IR_Out)
  );

  assign Envelope = envelope_reg;
  assign Ready    = ready_reg;

endmodule

// File: tb/tb_remote_transmitter.sv
// Directed bench for remote_transmitter with short units (8 cycles) and a
// 2-cycle carrier half-period; expected waveforms are built from hand-written run lengths.
module tb_remote_transmitter;

  localparam int U         = 8;
  localparam int CH        = 2;
  localparam int FU        = 192;
  localparam int FRAME_CYC = FU * U;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Valid;
  logic       Ready;
  logic [7:0] Address;
  logic [7:0] Command;
  logic       Repeat;
  logic       Envelope;
  logic       IR_Out;

  int checks = 0;
  int passed = 0;

  logic env_cap [FRAME_CYC];
  logic ir_cap  [FRAME_CYC];
  logic rdy_cap [FRAME_CYC];
  logic exp_env [FRAME_CYC];
  logic exp_ir  [FRAME_CYC];
  int   build_idx;
  logic final_ready;

  always #5 Clk = ~Clk;

  remote_transmitter #(
    .UNIT_CYCLES  (U),
    .CARRIER_HALF (CH),
    .FRAME_UNITS  (FU)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Valid    (Valid),
    .Ready    (Ready),
    .Address  (Address),
    .Command  (Command),
    .Repeat   (Repeat),
    .Envelope (Envelope),
    .IR_Out   (IR_Out)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic add_run(input int len, input logic mark);
    for (int j = 0; j < len; j++) begin
      if (build_idx < FRAME_CYC) begin
        exp_env[build_idx] = mark;
        exp_ir[build_idx]  = mark && ((j % (2 * CH)) < CH);
      end
      build_idx++;
    end
  endtask

  // Bytes are given in air order: b0 is sent first, each LSB first.
  task automatic build_expected(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic rep);
    logic [31:0] bits;
    bits = {b3, b2, b1, b0};
    for (int i = 0; i < FRAME_CYC; i++) begin
      exp_env[i] = 1'b0;
      exp_ir[i]  = 1'b0;
    end
    build_idx = 0;
    add_run(16 * U, 1'b1);
    if (rep) begin
      add_run(4 * U, 1'b0);
      add_run(U, 1'b1);
    end else begin
      add_run(8 * U, 1'b0);
      for (int k = 0; k < 32; k++) begin
        add_run(U, 1'b1);
        add_run(bits[k] ? 3 * U : U, 1'b0);
      end
      add_run(U, 1'b1);
    end
  endtask

  // Requests a frame, then samples ncyc cycles starting with the cycle after acceptance.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] c, input logic rep, input int ncyc);
    int n;
    n = 0;
    Address = a;
    Command = c;
    Repeat  = rep;
    Valid   = 1'b1;
    while (Ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (Ready !== 1'b1) begin
      checks++;
      $display("FAIL ready_wait: Ready=%b after %0d cycles, required 1", Ready, n);
    end
    tick();
    Valid   = 1'b0;
    Address = ~a;
    Command = ~c;
    Repeat  = ~rep;
    for (int i = 0; i < ncyc; i++) begin
      env_cap[i] = Envelope;
      ir_cap[i]  = IR_Out;
      rdy_cap[i] = Ready;
      Valid = (i == 500);
      tick();
    end
    Valid = 1'b0;
    final_ready = Ready;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Valid = 1'b0; Address = 8'h00; Command = 8'h00; Repeat = 1'b0;
    repeat (3) tick();
    checks++;
    if (Envelope !== 1'b0) $display("FAIL reset_envelope: got %b required 0", Envelope);
    else passed++;
    checks++;
    if (IR_Out !== 1'b0) $display("FAIL reset_ir_out: got %b required 0", IR_Out);
    else passed++;
    checks++;
    if (Ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", Ready);
    else passed++;
    Reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_data_frame();
    int bad, first, hi, lo;
    build_expected(8'h00, 8'hFF, 8'h45, 8'hBA, 1'b0);
    run_frame(8'h00, 8'h45, 1'b0, FRAME_CYC);
    checks++;
    if (env_cap[0] !== 1'b1) $display("FAIL data_env_latency: got %b required 1", env_cap[0]);
    else passed++;
    hi = 0;
    while (hi < FRAME_CYC && env_cap[hi] === 1'b1) hi++;
    lo = 0;
    while (hi + lo < FRAME_CYC && env_cap[hi + lo] === 1'b0) lo++;
    checks++;
    if (hi !== 128) $display("FAIL data_lead_mark: got %0d cycles required 128", hi);
    else passed++;
    checks++;
    if (lo !== 64) $display("FAIL data_lead_space: got %0d cycles required 64", lo);
    else passed++;
    bad = 0; first = -1;
    for (int i = 0; i < FRAME_CYC; i++)
      if (env_cap[i] !== exp_env[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) $display("FAIL data_envelope: %0d bad cycles, first at %0d got %b required %b",
                           bad, first, env_cap[first], exp_env[first]);
    else passed++;
    bad = 0;
    for (int i = 0; i < FRAME_CYC; i++) if (rdy_cap[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) $display("FAIL data_ready_busy: Ready high in %0d busy cycles, required 0", bad);
    else passed++;
    checks++;
    if (final_ready !== 1'b1) $display("FAIL data_ready_return: got %b at cycle 1536 required 1", final_ready);
    else passed++;
    $display("test_data_frame addr=00 cmd=45 done");
  endtask

  task automatic test_carrier();
    int bad, first;
    logic [7:0] lead_got;
    logic [7:0] lead_exp;
    lead_exp = 8'b0011_0011;
    build_expected(8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b0);
    run_frame(8'hA5, 8'h3C, 1'b0, FRAME_CYC);
    for (int i = 0; i < 8; i++) lead_got[i] = ir_cap[i];
    checks++;
    if (lead_got !== lead_exp) $display("FAIL carrier_lead: got %b required %b (bit0 first)", lead_got, lead_exp);
    else passed++;
    bad = 0;
    for (int i = 0; i < FRAME_CYC; i++) if (env_cap[i] === 1'b0 && ir_cap[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) $display("FAIL carrier_space_zero: IR_Out high in %0d space cycles, required 0", bad);
    else passed++;
    bad = 0; first = -1;
    for (int i = 0; i < FRAME_CYC; i++)
      if (ir_cap[i] !== exp_ir[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) $display("FAIL carrier_ir_out: %0d bad cycles, first at %0d got %b required %b",
                           bad, first, ir_cap[first], exp_ir[first]);
    else passed++;
    bad = 0; first = -1;
    for (int i = 0; i < FRAME_CYC; i++)
      if (env_cap[i] !== exp_env[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) $display("FAIL carrier_envelope: %0d bad cycles, first at %0d got %b required %b",
                           bad, first, env_cap[first], exp_env[first]);
    else passed++;
    $display("test_carrier addr=A5 cmd=3C done");
  endtask

  task automatic test_repeat_frame();
    int bad, first;
    build_expected(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    run_frame(8'h77, 8'h88, 1'b1, FRAME_CYC);
    bad = 0; first = -1;
    for (int i = 0; i < FRAME_CYC; i++)
      if (env_cap[i] !== exp_env[i] || ir_cap[i] !== exp_ir[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) $display("FAIL repeat_waveform: %0d bad cycles, first at %0d got env=%b ir=%b required env=%b ir=%b",
                           bad, first, env_cap[first], ir_cap[first], exp_env[first], exp_ir[first]);
    else passed++;
    checks++;
    if (rdy_cap[FRAME_CYC - 1] !== 1'b0 || final_ready !== 1'b1)
      $display("FAIL repeat_ready: got %b%b at cycles 1535/1536 required 01", rdy_cap[FRAME_CYC - 1], final_ready);
    else passed++;
    $display("test_repeat_frame done");
  endtask

  task automatic test_back_to_back();
    int acc_n, acc0, acc1, n;
    acc_n = 0; acc0 = -1; acc1 = -1;
    Address = 8'h10; Command = 8'h20; Repeat = 1'b0; Valid = 1'b1;
    for (int c = 0; c < 1737; c++) begin
      if (Ready === 1'b1 && Valid === 1'b1) begin
        if (acc_n == 0) acc0 = c;
        else if (acc_n == 1) acc1 = c;
        acc_n++;
      end
      tick();
    end
    Valid = 1'b0;
    checks++;
    if (acc_n !== 2) $display("FAIL b2b_count: got %0d acceptances required 2", acc_n);
    else passed++;
    checks++;
    if (acc1 - acc0 !== 1537) $display("FAIL b2b_spacing: got %0d cycles required 1537", acc1 - acc0);
    else passed++;
    n = 0;
    while (Ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (Ready !== 1'b1) begin
      checks++;
      $display("FAIL b2b_idle_wait: Ready=%b after %0d cycles, required 1", Ready, n);
    end
    $display("test_back_to_back acceptances=%0d spacing=%0d", acc_n, acc1 - acc0);
  endtask

  task automatic test_reset_mid_frame();
    int bad, first;
    run_frame(8'h00, 8'h45, 1'b0, 300);
    Reset = 1'b1;
    tick();
    checks++;
    if ({Envelope, IR_Out, Ready} !== 3'b001)
      $display("FAIL midreset_outputs: got env=%b ir=%b ready=%b required env=0 ir=0 ready=1", Envelope, IR_Out, Ready);
    else passed++;
    Reset = 1'b0;
    tick();
    build_expected(8'h12, 8'hED, 8'h34, 8'hCB, 1'b0);
    run_frame(8'h12, 8'h34, 1'b0, FRAME_CYC);
    bad = 0; first = -1;
    for (int i = 0; i < FRAME_CYC; i++)
      if (env_cap[i] !== exp_env[i] || ir_cap[i] !== exp_ir[i]) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (bad != 0) $display("FAIL midreset_next_frame: %0d bad cycles, first at %0d got env=%b ir=%b required env=%b ir=%b",
                           bad, first, env_cap[first], ir_cap[first], exp_env[first], exp_ir[first]);
    else passed++;
    checks++;
    if (final_ready !== 1'b1) $display("FAIL midreset_ready_return: got %b required 1", final_ready);
    else passed++;
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_reset_with_valid();
    int highs, busy;
    Address = 8'h55; Command = 8'hAA; Repeat = 1'b0;
    Reset = 1'b1; Valid = 1'b1;
    repeat (3) tick();
    checks++;
    if (Envelope !== 1'b0 || Ready !== 1'b1)
      $display("FAIL rstvalid_during: got env=%b ready=%b required env=0 ready=1", Envelope, Ready);
    else passed++;
    Reset = 1'b0; Valid = 1'b0;
    highs = 0; busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Envelope !== 1'b0) highs++;
      if (Ready !== 1'b1) busy++;
    end
    checks++;
    if (highs != 0) $display("FAIL rstvalid_envelope: Envelope high %0d of 10 cycles, required 0", highs);
    else passed++;
    checks++;
    if (busy != 0) $display("FAIL rstvalid_ready: Ready low %0d of 10 cycles, required 0", busy);
    else passed++;
    $display("test_reset_with_valid done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_data_frame();
    test_carrier();
    test_repeat_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_with_valid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/remote_transmitter.md
REMOTE_TRANSMITTER -- requirements
Module: remote_transmitter

Interface
REQ-001 Parameters SHALL be exactly:
  - `UNIT_CYCLES`, default 28125, Clk cycles per 562.5 us NEC unit at 50 MHz.
  - `CARRIER_HALF`, default 658, Clk cycles per carrier half-period (about 38 kHz).
  - `FRAME_UNITS`, default 192, frame-start to next-frame-start spacing in units (108 ms).
REQ-002 Ports SHALL be exactly:
  - `Clk  in  1`  sole clock; all logic on its rising edge.
  - `Reset  in  1`  synchronous, active-high.
  - `Valid  in  1`  request strobe.
  - `Ready  out  1`  high when a request can be accepted.
  - `Address  in  8`  NEC address.
  - `Command  in  8`  NEC command.
  - `Repeat  in  1`  when 1, send a repeat code; Address/Command ignored.
  - `Envelope  out  1`  unmodulated mark (1) / space (0).
  - `IR_Out  out  1`  carrier-modulated LED drive.

Function
REQ-003 A request SHALL be accepted on the rising edge where Valid=1 and Ready=1; Address, Command and Repeat are captured on that edge.
REQ-004 Ready SHALL be 1 only in IDLE; it falls on the cycle after acceptance and stays 0 until the frame period ends.
REQ-005 The FSM SHALL have these states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
REQ-006 A data frame SHALL be sent as:
  - LEAD_MARK for 16 units, then LEAD_SPACE for 8 units.
  - 32 bits, each as BIT_MARK for 1 unit then BIT_SPACE (1 unit for a 0 bit, 3 units for a 1 bit).
  - STOP_MARK for 1 unit, then GAP.
REQ-007 The bit order SHALL be Address, ~Address, Command, ~Command, each byte LSB first (shift register of 32 bits, right shift).
REQ-008 A repeat frame SHALL be sent as LEAD_MARK 16 units, LEAD_SPACE 4 units, STOP_MARK 1 unit, then GAP.
REQ-009 GAP SHALL last until exactly FRAME_UNITS units have elapsed since acceptance, then go to IDLE with Ready=1 on the following cycle.
REQ-010 A 1-unit unit-tick counter (0..UNIT_CYCLES-1, wraps) and a frame unit counter SHALL both restart at acceptance.
REQ-011 Envelope SHALL be 1 exactly in LEAD_MARK, BIT_MARK and STOP_MARK, and is registered.
REQ-012 Envelope SHALL rise on the first cycle after acceptance (1-cycle latency).
REQ-013 Envelope SHALL be high for exactly 16*UNIT_CYCLES cycles in LEAD_MARK and UNIT_CYCLES cycles in each 1-unit mark.
REQ-014 The carrier counter (0..CARRIER_HALF-1) SHALL restart at every 0->1 Envelope transition; IR_Out SHALL be high for the first CARRIER_HALF cycles of each mark, then toggle every CARRIER_HALF cycles.
REQ-015 IR_Out SHALL be 0 whenever Envelope=0, is registered, and has no glitches.
REQ-016 Valid asserted while Ready=0 SHALL be ignored (no queuing); a held Valid is accepted on the first Ready=1 edge.
REQ-017 Address, Command and Repeat changes after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-018 While Reset=1 at a rising edge, the next state SHALL be IDLE and all counters and the shift register SHALL be 0.
REQ-019 Reset values SHALL be Envelope=0, IR_Out=0, Ready=1.
REQ-020 Reset asserted mid-frame SHALL abort it immediately, with no stop mark and no gap.
REQ-021 Reset=1 together with Valid=1 SHALL result in no acceptance.

Structure
REQ-022 The FSM state encoding, NEC unit counts (16, 8, 4, 1, 3) and the 32-bit frame length SHALL be constants in the shared remote package, together with the receiver decoder.
REQ-023 One sub-module SHALL be used: remote_carrier (counter plus toggle, enabled by Envelope, restart on rising Envelope).

Verification
Benches run with `UNIT_CYCLES`=8, `CARRIER_HALF`=2, `FRAME_UNITS`=192.
REQ-024 Data frame: Address=0x00, Command=0x45, Repeat=0 ->
  - Envelope high 128 cycles, low 64.
  - 32 marks of 8 cycles; spaces follow the bits of 0x00, 0xFF, 0x45, 0xBA LSB first.
  - Stop mark of 8 cycles; Ready=1 again 1536 cycles after acceptance.
REQ-025 Repeat frame: Repeat=1 -> Envelope high 128, low 32, high 8, then 0; Ready returns 1536 cycles after acceptance.
REQ-026 Carrier: during the lead mark, IR_Out = 1,1,0,0 repeating, starting the cycle after acceptance; IR_Out=0 during every space.
REQ-027 Back-pressure: Valid held high across two frames -> exactly two acceptances, 1537 cycles apart; Valid pulses while busy are ignored.
REQ-028 Reset mid-bit (cycle 300 of a data frame) -> next cycle Envelope=0, IR_Out=0, Ready=1; a new request is then sent in full.
REQ-029 Reset with Valid=1 -> no frame starts; Envelope stays 0 for 10 cycles after Reset falls with Valid=0.
